gcd_controller: RTL

Sequencing FSM for the 5-bit subtract-and-swap GCD datapath (`datapath`: mux A, mux B, registers A/B, subtractor, `B_eq_0` and `A_lessThan_B` comparators). It loads the two operands, runs Euclid's algorithm by issuing one swap or subtract per cycle, and holds the result on the datapath `Result` port behind a done/ack handshake. It also reports how many datapath operations the computation took. It sits beside `datapath` inside the GCD top level and drives all of that block's control inputs.

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_controller_if.sv | 30 +++
 rtl/sat_counter.sv | 35 +++
 rtl/gcd_controller.sv | 84 ++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared constants for the GCD controller and its datapath.
package gcd_pkg;

  // Datapath operand width; the op counter is one bit wider.
  localparam int unsigned NUM_OF_BITS = 5;
  localparam int unsigned CNT_W       = NUM_OF_BITS + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } gcd_state_e;

  // Mux A select
  localparam logic [1:0] ASEL_IN  = 2'd0;
  localparam logic [1:0] ASEL_SUB = 2'd1;
  localparam logic [1:0] ASEL_B   = 2'd2;

  // Mux B select
  localparam logic BSEL_A  = 1'b0;
  localparam logic BSEL_IN = 1'b1;

endpackage

// File: rtl/gcd_controller_if.sv
// Handshake, datapath control and status signals between the GCD controller and its environment.
interface gcd_controller_if;
  import gcd_pkg::*;

  logic             start;
  logic             ack;
  logic             B_eq_0;
  logic             A_lessThan_B;
  logic [1:0]       Asel;
  logic             Aen;
  logic             Bsel;
  logic             Ben;
  logic             ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cycles;

  // Controller side
  modport master (
    input  start, ack, B_eq_0, A_lessThan_B,
    output Asel, Aen, Bsel, Ben, ready, busy, done, cycles
  );

  // Environment side (top level / datapath / consumer)
  modport slave (
    output start, ack, B_eq_0, A_lessThan_B,
    input  Asel, Aen, Bsel, Ben, ready, busy, done, cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Clear wins over increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/gcd_controller.sv
// Sequencer for the subtract-and-swap GCD datapath: load, iterate, hold result behind done/ack.
module gcd_controller
  import gcd_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  gcd_controller_if.master bus_io
);

  gcd_state_e state_q, state_d;
  logic       cnt_clr, cnt_inc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; in CALC a pending swap takes priority over the B==0 finish test.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus_io.start) state_d = StCalc;
      StCalc:  if (!bus_io.A_lessThan_B && bus_io.B_eq_0) state_d = StDone;
      StDone:  if (bus_io.ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath controls; gated by reset so a held start cannot load during reset.
  always_comb begin
    bus_io.Asel = ASEL_IN;
    bus_io.Aen  = 1'b0;
    bus_io.Bsel = BSEL_A;
    bus_io.Ben  = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            bus_io.Asel = ASEL_IN;
            bus_io.Aen  = 1'b1;
            bus_io.Bsel = BSEL_IN;
            bus_io.Ben  = 1'b1;
            cnt_clr     = 1'b1;
          end
        end
        StCalc: begin
          if (bus_io.A_lessThan_B) begin
            bus_io.Asel = ASEL_B;
            bus_io.Aen  = 1'b1;
            bus_io.Bsel = BSEL_A;
            bus_io.Ben  = 1'b1;
            cnt_inc     = 1'b1;
          end else if (!bus_io.B_eq_0) begin
            bus_io.Asel = ASEL_SUB;
            bus_io.Aen  = 1'b1;
            cnt_inc     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_io.ready = (state_q == StIdle);
  assign bus_io.busy  = (state_q == StCalc);
  assign bus_io.done  = (state_q == StDone);

  sat_counter #(
    .Width (CNT_W)
  ) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (bus_io.cycles)
  );

endmodule
